// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_buf
// Description : In-order instruction fetch buffer between the PC register and
//               IF/ID. Optional stall counter enabled by IFETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_buf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_ce_i,
    input  logic              flush_i,
    output logic              fetch_stall_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [ADDR_W-1:0]  r_pc   [DEPTH];
    logic [DATA_W-1:0]  r_inst [DEPTH];
    logic [DEPTH-1:0]   r_filled;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_fill_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_pend;
    logic [c_CNT_W-1:0] r_drop;

    logic               w_grant;
    logic               w_pop;
    logic               w_fill;
    logic               w_drop_rsp;
    logic [c_CNT_W-1:0] w_inflight;

    assign imem_req_o    = pc_ce_i & ~flush_i & (r_count < c_FULL) & (r_drop == '0);
    assign imem_addr_o   = pc_i;
    assign w_grant       = imem_req_o & imem_gnt_i;
    assign fetch_stall_o = pc_ce_i & ~w_grant & ~flush_i;

    assign inst_valid_o  = r_filled[r_rd_ptr];
    assign inst_o        = inst_valid_o ? r_inst[r_rd_ptr] : '0;
    assign inst_pc_o     = inst_valid_o ? r_pc[r_rd_ptr]   : '0;
    assign w_pop         = inst_valid_o & inst_ready_i & ~flush_i;

    // Responses owed to a flushed stream are consumed before any are written;
    // a response with nothing outstanding falls through both terms and is lost.
    assign w_drop_rsp    = imem_rvalid_i & (r_drop != '0);
    assign w_fill        = imem_rvalid_i & (r_drop == '0) & (r_pend != '0) & ~flush_i;
    assign w_inflight    = r_drop + r_pend;

    always_ff @(posedge clk) begin
        if (w_grant) r_pc[r_wr_ptr] <= pc_i;
        if (w_fill)  r_inst[r_fill_ptr] <= imem_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filled   <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_drop     <= '0;
        end else if (flush_i) begin
            r_filled   <= '0;
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            // A response arriving in the flush cycle retires one owed reply.
            r_drop     <= (imem_rvalid_i && (w_inflight != '0)) ? (w_inflight - c_CNT_ONE)
                                                                : w_inflight;
        end else begin
            if (w_grant) begin
                r_filled[r_wr_ptr] <= 1'b0;
                r_wr_ptr           <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_fill) begin
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_filled[r_rd_ptr] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + (w_grant ? c_CNT_ONE : '0) - (w_pop ? c_CNT_ONE : '0);
            r_pend  <= r_pend + (w_grant ? c_CNT_ONE : '0) - (w_fill ? c_CNT_ONE : '0);
            if (w_drop_rsp) r_drop <= r_drop - c_CNT_ONE;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= '0;
        end else if (fetch_stall_o && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_buf
// Description : Directed self-checking bench for if_fetch_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_buf;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_ce_i;
    logic        flush_i;
    logic        fetch_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_o;
`endif

    int n_vec;
    int n_err;

    if_fetch_buf #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_ce_i       (pc_ce_i),
        .flush_i       (flush_i),
        .fetch_stall_o (fetch_stall_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] p);
        return 32'hA000_0000 | p;
    endfunction

    // Advance to just after the next edge, apply inputs, let them settle.
    task automatic cyc(input logic ce, input logic [31:0] pc, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic fl);
        @(posedge clk);
        #1;
        pc_ce_i = ce; pc_i = pc; imem_gnt_i = gnt; imem_rvalid_i = rv;
        imem_rdata_i = rd; inst_ready_i = rdy; flush_i = fl;
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_pc [4];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        pc_ce_i = 0; pc_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
        imem_rdata_i = 0; inst_ready_i = 0; flush_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check_vec("rst_valid", 64'(inst_valid_o), 64'd0);
        check_vec("rst_req",   64'(imem_req_o),   64'd0);
        check_vec("rst_stall", 64'(fetch_stall_o), 64'd0);
        check_vec("rst_inst",  64'(inst_o),       64'd0);
        check_vec("rst_pc",    64'(inst_pc_o),    64'd0);

        // Streaming, k=1, decode always ready
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 32'(4*i), 1'b1, (i >= 1), ins(32'(4*(i-1))), 1'b1, 1'b0);
            check_vec("str_req",   64'(imem_req_o), 64'd1);
            check_vec("str_addr",  64'(imem_addr_o), 64'(4*i));
            check_vec("str_stall", 64'(fetch_stall_o), 64'd0);
            check_vec("str_valid", 64'(inst_valid_o), 64'(i >= 2));
            if (i >= 2) begin
                check_vec("str_pc",   64'(inst_pc_o), 64'(4*(i-2)));
                check_vec("str_inst", 64'(inst_o), 64'(ins(32'(4*(i-2)))));
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'h14), 1'b1, 1'b0);
        check_vec("str_drain0", 64'(inst_pc_o), 64'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("str_drain1", 64'(inst_pc_o), 64'h14);
        check_vec("str_stall_d", 64'(fetch_stall_o), 64'd0);
        idle();
        check_vec("str_empty", 64'(inst_valid_o), 64'd0);

        // Full: decode not ready, 4 grants fill the buffer
        for (int j = 0; j < 4; j++)
            cyc(1'b1, 32'(4*j), 1'b1, (j >= 1), ins(32'(4*(j-1))), 1'b0, 1'b0);
        cyc(1'b1, 32'h10, 1'b1, 1'b1, ins(32'hC), 1'b0, 1'b0);
        check_vec("full_req",   64'(imem_req_o), 64'd0);
        check_vec("full_stall", 64'(fetch_stall_o), 64'd1);
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("full_pop_req", 64'(imem_req_o), 64'd0);
        check_vec("full_pop_pc",  64'(inst_pc_o), 64'h0);
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_vec("full_reissue", 64'(imem_req_o), 64'd1);
        check_vec("full_stall2",  64'(fetch_stall_o), 64'd0);
        check_vec("full_head",    64'(inst_pc_o), 64'h4);
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 32'h0, 1'b0, (j == 0), ins(32'h10), 1'b1, 1'b0);
            check_vec("full_drain", 64'(inst_pc_o), 64'(exp_pc[j]));
        end
        idle();
        check_vec("full_empty", 64'(inst_valid_o), 64'd0);

        // Grant wait at 0x10
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check_vec("gw_stall", 64'(fetch_stall_o), 64'd1);
        end
        cyc(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_vec("gw_granted", 64'(fetch_stall_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'h10), 1'b1, 1'b0);
        check_vec("gw_lat", 64'(inst_valid_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("gw_pc",   64'(inst_pc_o), 64'h10);
        check_vec("gw_inst", 64'(inst_o), 64'(ins(32'h10)));

        // Flush with two requests in flight
        cyc(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_vec("fl_req_in_flush", 64'(imem_req_o), 64'd0);
        cyc(1'b1, 32'h100, 1'b1, 1'b1, 32'hDEAD_0040, 1'b1, 1'b0);
        check_vec("fl_drop_req0", 64'(imem_req_o), 64'd0);
        check_vec("fl_drop_stall", 64'(fetch_stall_o), 64'd1);
        check_vec("fl_valid0", 64'(inst_valid_o), 64'd0);
        cyc(1'b1, 32'h100, 1'b1, 1'b1, 32'hDEAD_0044, 1'b1, 1'b0);
        check_vec("fl_drop_req1", 64'(imem_req_o), 64'd0);
        check_vec("fl_valid1", 64'(inst_valid_o), 64'd0);
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("fl_resume", 64'(imem_req_o), 64'd1);
        check_vec("fl_valid2", 64'(inst_valid_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'h100), 1'b1, 1'b0);
        check_vec("fl_valid3", 64'(inst_valid_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("fl_pc",   64'(inst_pc_o), 64'h100);
        check_vec("fl_inst", 64'(inst_o), 64'(ins(32'h100)));

        // Flush coinciding with a response
        cyc(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b1, 1'b1, ins(32'h200), 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0204, 1'b1, 1'b1);
        check_vec("fr_head_pre", 64'(inst_pc_o), 64'h200);
        cyc(1'b1, 32'h300, 1'b1, 1'b1, 32'hDEAD_0208, 1'b1, 1'b0);
        check_vec("fr_valid0", 64'(inst_valid_o), 64'd0);
        check_vec("fr_req0",   64'(imem_req_o), 64'd0);
        cyc(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("fr_req1",   64'(imem_req_o), 64'd1);
        check_vec("fr_valid1", 64'(inst_valid_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'h300), 1'b1, 1'b0);
        check_vec("fr_valid2", 64'(inst_valid_o), 64'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_vec("fr_pc",   64'(inst_pc_o), 64'h300);
        check_vec("fr_inst", 64'(inst_o), 64'(ins(32'h300)));

        // Stray response with nothing outstanding is ignored
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
        idle();
        check_vec("stray_valid", 64'(inst_valid_o), 64'd0);

        // Reset with three entries buffered
        for (int j = 0; j < 4; j++)
            cyc((j < 3), 32'(32'h500 + 4*j), (j < 3), (j >= 1), ins(32'(32'h500 + 4*(j-1))),
                1'b0, 1'b0);
        idle();
        check_vec("rm_pre_valid", 64'(inst_valid_o), 64'd1);
        check_vec("rm_pre_pc",    64'(inst_pc_o), 64'h500);
        rst = 1'b1;
        cyc(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_vec("rm_valid", 64'(inst_valid_o), 64'd0);
        check_vec("rm_inst",  64'(inst_o), 64'd0);
        check_vec("rm_pc",    64'(inst_pc_o), 64'd0);
        check_vec("rm_req",   64'(imem_req_o), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
        check_vec("rm_perf",  64'(perf_stall_cnt_o), 64'd0);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
